// File: rtl/fp_posit4_result_pack_pkg.sv
// Shared constants and types for the posit x FP16 product packer.
// Holds the captured-product record and the leading-one helper.
package posit_fp_pkg;

    localparam int EXP_WIDTH = 5;
    localparam int MAN_WIDTH = 10;
    localparam int FIX_INT   = 4;
    localparam int FIX_W     = 14;

    localparam logic [4:0]  FP16_BIAS    = 5'd15;
    localparam logic [15:0] FP16_QNAN    = 16'h7E00;
    localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

    typedef struct packed {
        logic        sign;
        logic [4:0]  exp;
        logic [13:0] mant;
        logic        zero;
        logic        nar;
    } product_t;

    // Index of the most significant set bit; 0 when the input is zero.
    function automatic logic [3:0] lead_one(input logic [13:0] m);
        logic [3:0] p;
        p = 4'd0;
        for (int i = 0; i < FIX_W; i++) begin
            if (m[i]) begin
                p = 4'(i);
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/fp_posit4_result_pack_if.sv
// Product-in / FP16-out bus of the result packer.
// slave is the packer's view, master is the producer/consumer view.
interface fp_posit4_result_pack_if;
    import posit_fp_pkg::*;

    logic             sign_in;
    logic [4:0]       exp_in;
    logic [FIX_W-1:0] mant_in;
    logic             done_in;
    logic             zero_in;
    logic             nar_in;
    logic [15:0]      out_data;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  sign_in, exp_in, mant_in, done_in, zero_in, nar_in, out_ready,
        output out_data, out_valid
    );

    modport master (
        output sign_in, exp_in, mant_in, done_in, zero_in, nar_in, out_ready,
        input  out_data, out_valid
    );
endinterface

// File: rtl/fp_posit4_result_pack_norm.sv
// Combinational normalize + round-to-nearest-even of a 4.10 fixed product to FP16.
// No subnormals: underflow flushes to signed zero, overflow saturates to infinity.
module fp_norm_round
    import posit_fp_pkg::*;
(
    input  product_t    prod_i,
    output logic [15:0] fp_o
);

    logic [3:0]        lead_s;
    logic [3:0]        sh_s;
    logic signed [6:0] e_s;
    logic signed [6:0] e_fin_s;
    logic [9:0]        frac_raw_s;
    logic [9:0]        frac_s;
    logic [13:0]       low_mask_s;
    logic              guard_s;
    logic              sticky_s;
    logic              round_up_s;
    logic              carry_s;

    // Leading-one alignment to bit 10, RNE on right shifts, range check and special cases.
    always_comb begin
        lead_s     = lead_one(prod_i.mant);
        e_s        = $signed({2'b00, prod_i.exp}) + $signed({3'b000, lead_s}) - 7'sd10;
        sh_s       = 4'd0;
        low_mask_s = 14'd0;
        guard_s    = 1'b0;
        sticky_s   = 1'b0;
        round_up_s = 1'b0;
        frac_raw_s = 10'd0;
        if (lead_s > 4'd10) begin
            sh_s       = lead_s - 4'd10;
            frac_raw_s = 10'(prod_i.mant >> sh_s);
            guard_s    = prod_i.mant[sh_s - 4'd1];
            low_mask_s = (14'd1 << (sh_s - 4'd1)) - 14'd1;
            sticky_s   = |(prod_i.mant & low_mask_s);
            round_up_s = guard_s & (sticky_s | frac_raw_s[0]);
        end else begin
            frac_raw_s = 10'(prod_i.mant << (4'd10 - lead_s));
        end
        // A carry out of the 10-bit fraction means the significand reached 2.0.
        {carry_s, frac_s} = {1'b0, frac_raw_s} + {10'd0, round_up_s};
        e_fin_s = e_s + $signed({6'd0, carry_s});

        if (prod_i.nar) begin
            fp_o = FP16_QNAN;
        end else if (prod_i.zero) begin
            fp_o = 16'h0000;
        end else if (prod_i.mant == 14'd0) begin
            fp_o = {prod_i.sign, 15'h0000};
        end else if (e_fin_s >= 7'sd31) begin
            fp_o = {prod_i.sign, FP16_EXP_MAX, 10'h000};
        end else if (e_fin_s <= 7'sd0) begin
            fp_o = {prod_i.sign, 15'h0000};
        end else begin
            fp_o = {prod_i.sign, e_fin_s[4:0], frac_s};
        end
    end

endmodule

// File: rtl/fp_posit4_result_pack.sv
// Captures finished posit x FP16 products on the rising edge of done, converts them
// to FP16 through a two-stage pipeline and queues them in a small output FIFO.
module fp_posit4_result_pack
    import posit_fp_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    fp_posit4_result_pack_if.slave        bus,
    input  logic                          clr_err,
    output logic                          overflow_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic            done_q;
    logic            s1_valid_q;
    product_t        s1_prod_q;
    logic            s2_valid_q;
    logic [15:0]     s2_data_q;
    logic [15:0]     mem_q [FIFO_DEPTH];
    logic [15:0]     mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [15:0]     out_data_q, out_data_d;
    logic            out_valid_q;
    logic            overflow_q, overflow_d;

    logic            capture_s;
    logic            pop_s;
    logic            full_s;
    logic            push_ok_s;
    logic            drop_s;
    logic [15:0]     norm_s;
    product_t        in_prod_s;

    assign capture_s = bus.done_in & ~done_q;
    assign in_prod_s = '{sign: bus.sign_in, exp: bus.exp_in, mant: bus.mant_in,
                         zero: bus.zero_in, nar: bus.nar_in};

    fp_norm_round u_norm (
        .prod_i (s1_prod_q),
        .fp_o   (norm_s)
    );

    // FIFO bookkeeping; a push into a full FIFO is accepted only if the head leaves this cycle.
    always_comb begin
        pop_s     = (count_q != '0) & bus.out_ready;
        full_s    = (count_q == (AW+1)'(FIFO_DEPTH));
        push_ok_s = s2_valid_q & (~full_s | pop_s);
        drop_s    = s2_valid_q & full_s & ~pop_s;
        mem_d     = mem_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = s2_data_q;
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end
        wr_ptr_d = wr_ptr_q + AW'(push_ok_s);
        rd_ptr_d = rd_ptr_q + AW'(pop_s);
        count_d  = count_q + (AW+1)'(push_ok_s) - (AW+1)'(pop_s);
        if (count_d != '0) begin
            out_data_d = mem_d[rd_ptr_d];
        end else begin
            out_data_d = out_data_q;
        end
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Edge detect, capture stage, normalize stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= 16'h0000;
        end else begin
            done_q     <= bus.done_in;
            s1_valid_q <= capture_s;
            if (capture_s) begin
                s1_prod_q <= in_prod_s;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= norm_s;
            end
        end
    end

    // FIFO storage, pointers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_data_q  <= 16'h0000;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= (count_d != '0);
            overflow_q  <= overflow_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign overflow_err  = overflow_q;

endmodule

// File: tb/tb_fp_posit4_result_pack.sv
// Self-checking bench: directed vector table, random products against a real-valued
// FP16 model, and hand-written FIFO/overflow/reset sequences.
module tb_fp_posit4_result_pack;

    logic clk;
    logic rst;
    logic clr_err;
    logic overflow_err;

    fp_posit4_result_pack_if bus ();

    fp_posit4_result_pack #(.FIFO_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .clr_err      (clr_err),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        s;
        logic [4:0]  e;
        logic [13:0] m;
        logic        z;
        logic        n;
        logic [15:0] want;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Value = mant * 2^(exp-25); normalise with real arithmetic, round half to even.
    function automatic logic [15:0] model(input logic s, input logic [4:0] e,
                                          input logic [13:0] m, input logic z, input logic n);
        real v, x, diff;
        int  ex, fl, be;
        logic [15:0] r;
        if (n) return 16'h7E00;
        if (z) return 16'h0000;
        if (m == 14'd0) return {s, 15'h0000};
        v  = real'(m);
        ex = int'(e) - 25;
        while (v >= 2.0) begin v = v / 2.0; ex++; end
        while (v < 1.0)  begin v = v * 2.0; ex--; end
        x    = v * 1024.0;
        fl   = int'($floor(x));
        diff = x - real'(fl);
        if (diff > 0.5 || (diff == 0.5 && (fl % 2) == 1)) fl++;
        if (fl == 2048) begin fl = 1024; ex++; end
        be = ex + 15;
        if (be >= 31) return {s, 5'h1F, 10'h000};
        if (be <= 0)  return {s, 15'h0000};
        r = {s, 5'(be), 10'(fl - 1024)};
        return r;
    endfunction

    // Present a product for one cycle of done, then drop done; returns at the next negedge.
    task automatic send(input logic s, input logic [4:0] e, input logic [13:0] m,
                        input logic z, input logic n);
        bus.sign_in = s;
        bus.exp_in  = e;
        bus.mant_in = m;
        bus.zero_in = z;
        bus.nar_in  = n;
        bus.done_in = 1'b1;
        @(negedge clk);
        bus.done_in = 1'b0;
        @(negedge clk);
    endtask

    // Send one product with out_ready high and check latency and value.
    task automatic run_one(input string name, input logic s, input logic [4:0] e,
                           input logic [13:0] m, input logic z, input logic n,
                           input logic [15:0] want);
        send(s, e, m, z, n);
        check({name, " early_valid"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check({name, " valid"}, 32'(bus.out_valid), 32'd1);
        check({name, " data"}, 32'(bus.out_data), 32'(want));
    endtask

    initial begin
        int pops;
        logic s;
        logic [4:0] e;
        logic [13:0] m;
        logic z, n;

        vecs[0] = '{1'b0, 5'd15, 14'h0400, 1'b0, 1'b0, 16'h3C00};
        vecs[1] = '{1'b0, 5'd15, 14'h0C00, 1'b0, 1'b0, 16'h4200};
        vecs[2] = '{1'b0, 5'd15, 14'h0C01, 1'b0, 1'b0, 16'h4200};
        vecs[3] = '{1'b0, 5'd15, 14'h0C03, 1'b0, 1'b0, 16'h4202};
        vecs[4] = '{1'b0, 5'd15, 14'h3FFF, 1'b0, 1'b0, 16'h4C00};
        vecs[5] = '{1'b1, 5'd30, 14'h2000, 1'b0, 1'b0, 16'hFC00};
        vecs[6] = '{1'b0, 5'd5,  14'h0001, 1'b0, 1'b0, 16'h0000};
        vecs[7] = '{1'b0, 5'd15, 14'h0400, 1'b1, 1'b1, 16'h7E00};
        vecs[8] = '{1'b1, 5'd15, 14'h0400, 1'b1, 1'b0, 16'h0000};
        vecs[9] = '{1'b1, 5'd15, 14'h0000, 1'b0, 1'b0, 16'h8000};

        rst           = 1'b1;
        clr_err       = 1'b0;
        bus.sign_in   = 1'b0;
        bus.exp_in    = 5'd0;
        bus.mant_in   = 14'd0;
        bus.done_in   = 1'b0;
        bus.zero_in   = 1'b0;
        bus.nar_in    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_data", 32'(bus.out_data), 32'd0);
        check("reset overflow", 32'(overflow_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].s, vecs[i].e, vecs[i].m,
                    vecs[i].z, vecs[i].n, vecs[i].want);
        end
        repeat (2) @(negedge clk);

        // Held done produces exactly one result.
        bus.sign_in = 1'b0; bus.exp_in = 5'd15; bus.mant_in = 14'h0400;
        bus.zero_in = 1'b0; bus.nar_in = 1'b0; bus.done_in = 1'b1;
        pops = 0;
        for (int c = 0; c < 14; c++) begin
            if (c == 5) bus.done_in = 1'b0;
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                pops++;
                check("held data", 32'(bus.out_data), 32'h3C00);
            end
        end
        check("held pops", 32'(pops), 32'd1);

        // Random products against the model.
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom);
            e = 5'($urandom_range(0, 31));
            m = 14'($urandom);
            z = ($urandom_range(0, 15) == 0);
            n = ($urandom_range(0, 15) == 0);
            run_one($sformatf("rand%0d", i), s, e, m, z, n, model(s, e, m, z, n));
        end
        repeat (2) @(negedge clk);

        // Overflow: two held in order, third dropped.
        bus.out_ready = 1'b0;
        send(1'b0, 5'd15, 14'h0400, 1'b0, 1'b0);
        send(1'b0, 5'd16, 14'h0400, 1'b0, 1'b0);
        send(1'b0, 5'd17, 14'h0400, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("ovf flag", 32'(overflow_err), 32'd1);
        check("ovf valid", 32'(bus.out_valid), 32'd1);
        check("ovf head A", 32'(bus.out_data), 32'h3C00);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("ovf head B", 32'(bus.out_data), 32'h4000);
        check("ovf B valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        check("ovf drained", 32'(bus.out_valid), 32'd0);
        check("ovf hold last", 32'(bus.out_data), 32'h4000);
        repeat (2) @(negedge clk);
        check("ovf third gone", 32'(bus.out_valid), 32'd0);
        check("ovf sticky", 32'(overflow_err), 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("ovf cleared", 32'(overflow_err), 32'd0);

        // Full FIFO with pop and push on the same edge: nothing dropped.
        bus.out_ready = 1'b0;
        send(1'b0, 5'd15, 14'h0400, 1'b0, 1'b0);
        send(1'b0, 5'd16, 14'h0400, 1'b0, 1'b0);
        @(negedge clk);
        send(1'b0, 5'd17, 14'h0400, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("fpp no drop", 32'(overflow_err), 32'd0);
        check("fpp head B", 32'(bus.out_data), 32'h4000);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("fpp head C", 32'(bus.out_data), 32'h4400);
        check("fpp C valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        check("fpp drained", 32'(bus.out_valid), 32'd0);

        // Reset with one FIFO entry and one product in stage 2.
        bus.out_ready = 1'b0;
        send(1'b0, 5'd15, 14'h0400, 1'b0, 1'b0);
        send(1'b0, 5'd16, 14'h0400, 1'b0, 1'b0);
        check("pre-rst valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst valid", 32'(bus.out_valid), 32'd0);
        check("rst data", 32'(bus.out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.out_valid) pops++;
        end
        check("post-rst no output", 32'(pops), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
